// File: rtl/sig_checkpoint_pkg.sv
// Shared definitions for the checkpoint monitor: run-state encoding and fail-cause codes.
package sig_checkpoint_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPass  = 2'd2,
    StFail  = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ORDER   = 2'b10;
  localparam logic [1:0] FC_ABORT   = 2'b11;

endpackage

// File: rtl/sig_stable_match.sv
// Masked compare of a sampled word against one expected value, qualified by a
// saturating run counter so only a match held for STABLE_CYCLES samples counts.
module sig_stable_match #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_sig,
  input  logic [WIDTH-1:0] i_exp,
  input  logic [WIDTH-1:0] i_mask,
  output logic             o_match,
  output logic             o_match_stable
);

  localparam int unsigned    CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  MaxCnt  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  LastCnt = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;

  assign o_match = ((i_sig ^ i_exp) & i_mask) == '0;
  // Stable in the cycle whose increment would reach STABLE_CYCLES, so the
  // registered hit lands one cycle later.
  assign o_match_stable = o_match && (r_cnt >= LastCnt);

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr || !o_match) begin
      w_cnt_d = '0;
    end else if (r_cnt != MaxCnt) begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/sig_checkpoint_mon.sv
// Checkpoint monitor: waits for an ordered series of stable status values under a
// cycle watchdog and reports pass, fail and the fail cause.
module sig_checkpoint_mon #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned NUM_STAGES     = 2,
  parameter int unsigned STABLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 30000,
  parameter int unsigned TO_MODE        = 0,
  parameter int unsigned STRICT         = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic [WIDTH-1:0]                  sig_i,
  input  logic [WIDTH-1:0]                  mask_i,
  input  logic [NUM_STAGES*WIDTH-1:0]       exp_i,
  output logic                              busy_o,
  output logic                              pass_o,
  output logic                              fail_o,
  output logic [1:0]                        fail_code_o,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage_o,
  output logic                              hit_o,
  output logic [CNT_W-1:0]                  cycles_o
);

  import sig_checkpoint_pkg::*;

  localparam int unsigned      SW        = $clog2(NUM_STAGES + 1);
  localparam logic [SW-1:0]    LastStage = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0]    DoneStage = SW'(NUM_STAGES);
  localparam logic [CNT_W-1:0] ToLast    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  r_state, w_state_d;
  logic [WIDTH-1:0]        r_sig;
  logic [SW-1:0]           r_stage, w_stage_d;
  logic [CNT_W-1:0]        r_cycles, w_cycles_d, w_cycles_inc;
  logic                    r_pass, w_pass_d;
  logic                    r_fail, w_fail_d;
  logic                    r_hit, w_hit_d;
  logic [1:0]              r_code, w_code_d;
  logic [NUM_STAGES-1:0]   w_match, w_stable;
  logic                    w_armed, w_clr;
  logic                    w_cur_match, w_cur_stable, w_later, w_order, w_timeout;

  // Single sampling flop; the source is assumed synchronous or quasi-static.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sig <= '0;
    end else begin
      r_sig <= sig_i;
    end
  end

  assign w_armed = (r_state == StArmed);
  assign w_clr   = !w_armed || w_cur_stable;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    sig_stable_match #(
      .WIDTH        (WIDTH),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_match (
      .i_clk         (wb_clk_i),
      .i_rst         (wb_rst_i),
      .i_clr         (w_clr),
      .i_sig         (r_sig),
      .i_exp         (exp_i[k*WIDTH +: WIDTH]),
      .i_mask        (mask_i),
      .o_match       (w_match[k]),
      .o_match_stable(w_stable[k])
    );
  end

  always_comb begin
    w_cur_match  = 1'b0;
    w_cur_stable = 1'b0;
    w_later      = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (r_stage == SW'(k)) begin
        w_cur_match  = w_match[k];
        w_cur_stable = w_stable[k];
      end
      if ((SW'(k) > r_stage) && w_stable[k]) begin
        w_later = 1'b1;
      end
    end
  end

  assign w_order      = (STRICT != 0) && w_later && !w_cur_match;
  // >= rather than == so a non-final hit on the limit cycle cannot skip the timeout.
  assign w_timeout    = (r_cycles >= ToLast);
  assign w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + 1'b1;

  always_comb begin
    w_state_d  = r_state;
    w_stage_d  = r_stage;
    w_cycles_d = r_cycles;
    w_pass_d   = r_pass;
    w_fail_d   = r_fail;
    w_code_d   = r_code;
    w_hit_d    = 1'b0;
    unique case (r_state)
      StIdle, StPass, StFail: begin
        if (start_i) begin
          w_state_d  = StArmed;
          w_stage_d  = '0;
          w_cycles_d = '0;
          w_pass_d   = 1'b0;
          w_fail_d   = 1'b0;
          w_code_d   = FC_NONE;
        end
      end
      StArmed: begin
        if (abort_i) begin
          w_state_d = StFail;
          w_fail_d  = 1'b1;
          w_code_d  = FC_ABORT;
        end else if (w_cur_stable) begin
          w_hit_d = 1'b1;
          if (r_stage == LastStage) begin
            w_state_d = StPass;
            w_pass_d  = 1'b1;
            w_stage_d = DoneStage;
          end else begin
            w_stage_d  = r_stage + 1'b1;
            w_cycles_d = (TO_MODE != 0) ? '0 : w_cycles_inc;
          end
        end else if (w_order) begin
          w_state_d = StFail;
          w_fail_d  = 1'b1;
          w_code_d  = FC_ORDER;
        end else if (w_timeout) begin
          w_state_d = StFail;
          w_fail_d  = 1'b1;
          w_code_d  = FC_TIMEOUT;
        end else begin
          w_cycles_d = w_cycles_inc;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= StIdle;
      r_stage  <= '0;
      r_cycles <= '0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_code   <= FC_NONE;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_stage  <= w_stage_d;
      r_cycles <= w_cycles_d;
      r_pass   <= w_pass_d;
      r_fail   <= w_fail_d;
      r_code   <= w_code_d;
      r_hit    <= w_hit_d;
    end
  end

  assign busy_o      = w_armed;
  assign pass_o      = r_pass;
  assign fail_o      = r_fail;
  assign fail_code_o = r_code;
  assign stage_o     = r_stage;
  assign hit_o       = r_hit;
  assign cycles_o    = r_cycles;

endmodule

// File: tb/tb_sig_checkpoint_mon.sv
// Directed bench: two monitor instances (strict/global vs relaxed/per-stage watchdog)
// driven from a shared stimulus table plus hand-written multi-cycle sequences.
module tb_sig_checkpoint_mon;

  localparam logic [15:0] S0 = 16'hAB60;
  localparam logic [15:0] S1 = 16'hAB6A;

  logic        clk, rst, start, abort;
  logic [15:0] sig, mask;
  logic [31:0] expv;

  logic        busy_a, pass_a, fail_a, hit_a, busy_b, pass_b, fail_b, hit_b;
  logic [1:0]  code_a, stage_a, code_b, stage_b;
  logic [31:0] cycles_a, cycles_b;

  int checks = 0;
  int failures = 0;

  sig_checkpoint_mon #(
    .WIDTH(16), .NUM_STAGES(2), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(100),
    .TO_MODE(0), .STRICT(1), .CNT_W(32)
  ) u_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort), .sig_i(sig),
    .mask_i(mask), .exp_i(expv), .busy_o(busy_a), .pass_o(pass_a), .fail_o(fail_a),
    .fail_code_o(code_a), .stage_o(stage_a), .hit_o(hit_a), .cycles_o(cycles_a)
  );

  sig_checkpoint_mon #(
    .WIDTH(16), .NUM_STAGES(2), .STABLE_CYCLES(3), .TIMEOUT_CYCLES(100),
    .TO_MODE(1), .STRICT(0), .CNT_W(32)
  ) u_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .abort_i(abort), .sig_i(sig),
    .mask_i(mask), .exp_i(expv), .busy_o(busy_b), .pass_o(pass_b), .fail_o(fail_b),
    .fail_code_o(code_b), .stage_o(stage_b), .hit_o(hit_b), .cycles_o(cycles_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic        st, ab;
    logic [15:0] sig;
    logic        a_busy, a_pass, a_fail;
    logic [1:0]  a_code, a_stage;
    logic        a_hit;
    logic [31:0] a_cyc;
    logic        b_busy, b_pass, b_fail;
    logic [1:0]  b_code, b_stage;
    logic        b_hit;
  } vec_t;

  vec_t tbl [20];
  int   nv = 0;

  task automatic add(input logic st, input logic ab, input logic [15:0] s,
                     input logic aby, input logic apa, input logic afa, input logic [1:0] aco,
                     input logic [1:0] ast, input logic ahi, input logic [31:0] acy,
                     input logic bby, input logic bpa, input logic bfa, input logic [1:0] bco,
                     input logic [1:0] bst, input logic bhi);
    tbl[nv].st = st;  tbl[nv].ab = ab;  tbl[nv].sig = s;
    tbl[nv].a_busy = aby; tbl[nv].a_pass = apa; tbl[nv].a_fail = afa;
    tbl[nv].a_code = aco; tbl[nv].a_stage = ast; tbl[nv].a_hit = ahi; tbl[nv].a_cyc = acy;
    tbl[nv].b_busy = bby; tbl[nv].b_pass = bpa; tbl[nv].b_fail = bfa;
    tbl[nv].b_code = bco; tbl[nv].b_stage = bst; tbl[nv].b_hit = bhi;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Abort whatever is still running, then start both monitors; returns in armed cycle 1.
  task automatic arm(input logic [15:0] s);
    abort = 1'b1; step(); abort = 1'b0; step();
    sig = s; start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic late_hit(input int t, input logic want_pass);
    int done;
    done = 0;
    arm(S0);
    repeat (t - 1) step();
    sig = S1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (!busy_a) begin
        done = t + n;
        break;
      end
    end
    chk($sformatf("late%0d_end_cycle", t), done, 101);
    chk($sformatf("late%0d_pass", t), {31'd0, pass_a}, {31'd0, want_pass});
    chk($sformatf("late%0d_fail", t), {31'd0, fail_a}, {31'd0, !want_pass});
    chk($sformatf("late%0d_code", t), {30'd0, code_a}, want_pass ? 32'd0 : 32'd1);
    chk($sformatf("late%0d_stage", t), {30'd0, stage_a}, want_pass ? 32'd2 : 32'd1);
    chk($sformatf("late%0d_cycles", t), cycles_a, 99);
  endtask

  initial begin
    int fired, nh, hc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sig = '0; mask = 16'hFFFF;
    expv = {S1, S0};
    @(negedge clk);
    step();
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_pass", {31'd0, pass_a}, 0);
    chk("rst_fail", {31'd0, fail_a}, 0);
    chk("rst_code", {30'd0, code_a}, 0);
    chk("rst_stage", {30'd0, stage_a}, 0);
    chk("rst_hit", {31'd0, hit_a}, 0);
    chk("rst_cycles", cycles_a, 0);
    chk("rst_busy_b", {31'd0, busy_b}, 0);
    rst = 1'b0;

    //  st ab sig  | A busy pass fail code stage hit cyc | B busy pass fail code stage hit
    add(1, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, S0,    1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, S0,    1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, S0,    1, 0, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    add(0, 0, S0,    1, 0, 0, 0, 1, 0, 4, 1, 0, 0, 0, 1, 1);
    add(0, 0, S0,    1, 0, 0, 0, 1, 0, 5, 1, 0, 0, 0, 1, 0);
    add(0, 0, S1,    1, 0, 0, 0, 1, 0, 6, 1, 0, 0, 0, 1, 0);
    add(0, 0, S1,    1, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0, 1, 0);
    add(0, 0, S1,    0, 1, 0, 0, 2, 1, 7, 1, 0, 0, 0, 1, 0);
    add(0, 0, S1,    0, 1, 0, 0, 2, 0, 7, 0, 1, 0, 0, 2, 1);
    add(0, 0, S1,    0, 1, 0, 0, 2, 0, 7, 0, 1, 0, 0, 2, 0);
    add(1, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    add(0, 1, 16'h0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    add(1, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, S1,    1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, S1,    1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, S1,    0, 0, 1, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 16'h0, 0, 0, 1, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0);
    add(0, 1, 16'h0, 0, 0, 1, 2, 0, 0, 2, 0, 0, 1, 3, 0, 0);

    for (int i = 0; i < nv; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; sig = tbl[i].sig;
      step();
      chk($sformatf("v%0d_a_busy", i), {31'd0, busy_a}, {31'd0, tbl[i].a_busy});
      chk($sformatf("v%0d_a_pass", i), {31'd0, pass_a}, {31'd0, tbl[i].a_pass});
      chk($sformatf("v%0d_a_fail", i), {31'd0, fail_a}, {31'd0, tbl[i].a_fail});
      chk($sformatf("v%0d_a_code", i), {30'd0, code_a}, {30'd0, tbl[i].a_code});
      chk($sformatf("v%0d_a_stage", i), {30'd0, stage_a}, {30'd0, tbl[i].a_stage});
      chk($sformatf("v%0d_a_hit", i), {31'd0, hit_a}, {31'd0, tbl[i].a_hit});
      chk($sformatf("v%0d_a_cyc", i), cycles_a, tbl[i].a_cyc);
      chk($sformatf("v%0d_b_busy", i), {31'd0, busy_b}, {31'd0, tbl[i].b_busy});
      chk($sformatf("v%0d_b_pass", i), {31'd0, pass_b}, {31'd0, tbl[i].b_pass});
      chk($sformatf("v%0d_b_fail", i), {31'd0, fail_b}, {31'd0, tbl[i].b_fail});
      chk($sformatf("v%0d_b_code", i), {30'd0, code_b}, {30'd0, tbl[i].b_code});
      chk($sformatf("v%0d_b_stage", i), {30'd0, stage_b}, {30'd0, tbl[i].b_stage});
      chk($sformatf("v%0d_b_hit", i), {31'd0, hit_b}, {31'd0, tbl[i].b_hit});
    end
    start = 1'b0; abort = 1'b0;

    // Global watchdog with no hits: fail visible in cycle 101, counter frozen at 99.
    fired = 0;
    arm(16'h0);
    for (int n = 2; n <= 200; n++) begin
      step();
      if (n == 100) begin
        chk("to_cyc_at_100", cycles_a, 99);
        chk("to_busy_at_100", {31'd0, busy_a}, 1);
      end
      if (!busy_a) begin
        fired = n;
        break;
      end
    end
    chk("to_fire_cycle", fired, 101);
    chk("to_fail", {31'd0, fail_a}, 1);
    chk("to_code", {30'd0, code_a}, 1);
    chk("to_cycles", cycles_a, 99);
    chk("to_b_fail", {31'd0, fail_b}, 1);
    chk("to_b_code", {30'd0, code_b}, 1);

    // Final hit on the limit cycle beats the timeout; one cycle later loses.
    late_hit(98, 1'b1);
    late_hit(99, 1'b0);

    // Per-stage watchdog: B restarts at its stage-0 hit, A does not.
    arm(16'h0);
    repeat (79) step();
    sig = S0;
    repeat (90) step();
    sig = S1;
    repeat (5) step();
    chk("ps_a_fail", {31'd0, fail_a}, 1);
    chk("ps_a_code", {30'd0, code_a}, 1);
    chk("ps_a_stage", {30'd0, stage_a}, 1);
    chk("ps_b_pass", {31'd0, pass_b}, 1);
    chk("ps_b_fail", {31'd0, fail_b}, 0);
    chk("ps_b_stage", {30'd0, stage_b}, 2);
    chk("ps_b_cycles", cycles_b, 89);

    // Glitch filter on B: two-cycle blip ignored, held value hits in cycle 9 only.
    arm(16'h0);
    nh = 0; hc = 0;
    for (int k = 1; k <= 12; k++) begin
      sig = (k == 2 || k == 3 || k >= 5) ? S0 : 16'h0;
      step();
      if (hit_b) begin
        nh++;
        hc = k + 1;
      end
    end
    chk("glitch_hit_count", nh, 1);
    chk("glitch_hit_cycle", hc, 9);

    // start while armed is ignored; reset mid-run clears everything next cycle.
    arm(S0);
    repeat (5) step();
    start = 1'b1; step(); start = 1'b0;
    chk("rearm_ignored_cyc", cycles_a, 6);
    chk("rearm_ignored_stage", {30'd0, stage_a}, 1);
    rst = 1'b1; step();
    chk("midrst_busy", {31'd0, busy_a}, 0);
    chk("midrst_stage", {30'd0, stage_a}, 0);
    chk("midrst_cycles", cycles_a, 0);
    chk("midrst_flags", {28'd0, pass_a, fail_a, code_a}, 0);
    chk("midrst_hit", {31'd0, hit_a}, 0);
    chk("midrst_b", {29'd0, busy_b, stage_b}, 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
